alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 26 ++
 rtl/alu_sequencer.sv | 81 ++++++++
 tb/tb_alu_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake, ALU bus and status signals of the ALU sequencer
interface alu_sequencer_if #(parameter int WIDTH = 32);
  logic             INSTR_VALID;
  logic [15:0]      INSTR;
  logic             INSTR_READY;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [2:0]       ALU_OP;
  logic [WIDTH-1:0] ALU_O;
  logic             ALU_OF;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic             OF_STICKY;
  logic             CLR_OF;
  logic             TRAP;
  logic [2:0]       RD_ADDR;
  logic [WIDTH-1:0] RD_DATA;
  modport slave (
    input  INSTR_VALID, INSTR, ALU_O, ALU_OF, CLR_OF, RD_ADDR,
    output INSTR_READY, ALU_A, ALU_B, ALU_OP, DONE, RESULT, OF_STICKY, TRAP, RD_DATA
  );
  modport master (
    output INSTR_VALID, INSTR, ALU_O, ALU_OF, CLR_OF, RD_ADDR,
    input  INSTR_READY, ALU_A, ALU_B, ALU_OP, DONE, RESULT, OF_STICKY, TRAP, RD_DATA
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-cycle IDLE/READ/EXEC/WB sequencer over an external ALU with 8x WIDTH register file; ALU_SEQ_TRAP_EN enables overflow trap
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic CLK,
  input  logic RSTN,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t           state_q, state_d;
  logic [15:4]      instr_q;
  logic [WIDTH-1:0] rf_q [8];
  logic [WIDTH-1:0] a_q, b_q, res_q, result_q;
  logic [2:0]       op_q;
  logic             ovf_q, done_q, of_q, trap_q;
  logic             hs, wb, wr_en;
  // Next state: IDLE waits for a handshake, the other states last one cycle each
  always_comb begin
    state_d = state_q;
    hs      = state_q == IDLE && bus.INSTR_VALID;
    wb      = state_q == WB;
    state_d = state_q == IDLE ? (bus.INSTR_VALID ? READ : IDLE) :
              state_q == READ ? EXEC :
              state_q == EXEC ? WB : IDLE;
  end
  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Datapath: latch instruction, read operands, capture ALU, write back
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      of_q     <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      done_q <= wb;
      of_q   <= (wb && ovf_q) || (of_q && !bus.CLR_OF);
      if (hs) instr_q <= bus.INSTR[15:4];
      if (state_q == READ) begin
        a_q  <= rf_q[instr_q[9:7]];
        b_q  <= rf_q[instr_q[6:4]];
        op_q <= instr_q[15:13];
      end
      if (state_q == EXEC) begin
        res_q <= bus.ALU_O;
        ovf_q <= bus.ALU_OF;
      end
      if (wb) result_q <= res_q;
      if (wb && wr_en) rf_q[instr_q[12:10]] <= res_q;
    end
  end
`ifdef ALU_SEQ_TRAP_EN
  assign wr_en = instr_q[12:10] != 3'd0 && !ovf_q;
  // Trap flag: set by an overflowing writeback, cleared by the next handshake
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) trap_q <= 1'b0;
    else trap_q <= hs ? 1'b0 : (wb && ovf_q) ? 1'b1 : trap_q;
  end
`else
  assign wr_en  = instr_q[12:10] != 3'd0;
  assign trap_q = 1'b0;
`endif
  assign bus.INSTR_READY = state_q == IDLE;
  assign bus.ALU_A       = a_q;
  assign bus.ALU_B       = b_q;
  assign bus.ALU_OP      = op_q;
  assign bus.DONE        = done_q;
  assign bus.RESULT      = result_q;
  assign bus.OF_STICKY   = of_q;
  assign bus.TRAP        = trap_q;
  assign bus.RD_DATA     = rf_q[bus.RD_ADDR];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a small reference ALU
module tb_alu_sequencer;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int lat, rdy_cnt, done_cnt;
  logic trap_exp;
  alu_sequencer_if #(.WIDTH(32)) bus ();
  alu_sequencer #(.WIDTH(32)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
  always #5 CLK = ~CLK;
  assign bus.ALU_O  = bus.ALU_OP == 3'b111 ? bus.ALU_A + 32'd1 :
                      bus.ALU_OP == 3'b101 ? bus.ALU_A + bus.ALU_B :
                      bus.ALU_OP == 3'b001 ? bus.ALU_A - bus.ALU_B :
                      bus.ALU_OP == 3'b010 ? bus.ALU_A >> 1 : bus.ALU_A;
  assign bus.ALU_OF = bus.ALU_OP == 3'b111 ? bus.ALU_A == 32'h7FFF_FFFF :
                      bus.ALU_OP == 3'b101 ? (bus.ALU_A[31] == bus.ALU_B[31]) && (bus.ALU_O[31] != bus.ALU_A[31]) :
                      bus.ALU_OP == 3'b001 ? (bus.ALU_A[31] != bus.ALU_B[31]) && (bus.ALU_O[31] != bus.ALU_A[31]) : 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    bus.RD_ADDR = addr;
    #1;
    check(tag, bus.RD_DATA, exp);
  endtask
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb, output int l);
    int w;
    w = 0;
    bus.INSTR = {op, rd, ra, rb, 4'h0};
    bus.INSTR_VALID = 1'b1;
    while (!bus.INSTR_READY && w < 20) begin
      @(posedge CLK); #1; w++;
    end
    @(posedge CLK); #1;
    bus.INSTR_VALID = 1'b0;
    bus.INSTR = 16'hFFFF;
    l = 0;
    while (!bus.DONE && l < 10) begin
      @(posedge CLK); #1; l++;
    end
    check("done_seen", {31'd0, bus.DONE}, 32'd1);
  endtask
  initial begin
`ifdef ALU_SEQ_TRAP_EN
    trap_exp = 1'b1;
`else
    trap_exp = 1'b0;
`endif
    bus.INSTR_VALID = 1'b0;
    bus.INSTR = 16'h0;
    bus.CLR_OF = 1'b0;
    bus.RD_ADDR = 3'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_alu_a", bus.ALU_A, 32'd0);
    check("rst_result", bus.RESULT, 32'd0);
    check("rst_done", {31'd0, bus.DONE}, 32'd0);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    check("rst_ready", {31'd0, bus.INSTR_READY}, 32'd1);
    check("rst_of", {31'd0, bus.OF_STICKY}, 32'd0);
    check("rst_trap", {31'd0, bus.TRAP}, 32'd0);
    rd_chk("rst_r1", 3'd1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      issue(3'b111, 3'd1, 3'd1, 3'd0, lat);
      if (i == 0) check("lat_inc", lat, 32'd3);
    end
    rd_chk("r1_preload", 3'd1, 32'd5);
    issue(3'b101, 3'd2, 3'd1, 3'd1, lat);
    check("lat_add", lat, 32'd3);
    check("add_result", bus.RESULT, 32'd10);
    rd_chk("add_r2", 3'd2, 32'd10);
    issue(3'b101, 3'd2, 3'd2, 3'd2, lat);
    check("self_result", bus.RESULT, 32'd20);
    rd_chk("self_r2", 3'd2, 32'd20);
    issue(3'b101, 3'd0, 3'd1, 3'd1, lat);
    check("r0_result", bus.RESULT, 32'd10);
    rd_chk("r0_zero", 3'd0, 32'd0);
    issue(3'b111, 3'd6, 3'd0, 3'd0, lat);
    issue(3'b001, 3'd5, 3'd0, 3'd6, lat);
    rd_chk("sub_r5", 3'd5, 32'hFFFF_FFFF);
    issue(3'b010, 3'd1, 3'd5, 3'd0, lat);
    rd_chk("shr_r1", 3'd1, 32'h7FFF_FFFF);
    check("of_before", {31'd0, bus.OF_STICKY}, 32'd0);
    issue(3'b111, 3'd3, 3'd1, 3'd0, lat);
    check("ovf_result", bus.RESULT, 32'h8000_0000);
    check("ovf_sticky", {31'd0, bus.OF_STICKY}, 32'd1);
    check("ovf_trap", {31'd0, bus.TRAP}, {31'd0, trap_exp});
    rd_chk("ovf_r3", 3'd3, trap_exp ? 32'd0 : 32'h8000_0000);
    bus.CLR_OF = 1'b1;
    @(posedge CLK); #1;
    bus.CLR_OF = 1'b0;
    check("clr_of", {31'd0, bus.OF_STICKY}, 32'd0);
    check("trap_hold", {31'd0, bus.TRAP}, {31'd0, trap_exp});
    issue(3'b101, 3'd0, 3'd0, 3'd0, lat);
    check("trap_clear", {31'd0, bus.TRAP}, 32'd0);
    bus.CLR_OF = 1'b1;
    issue(3'b111, 3'd4, 3'd1, 3'd0, lat);
    check("set_wins", {31'd0, bus.OF_STICKY}, 32'd1);
    bus.CLR_OF = 1'b0;
    rd_chk("ovf_r4", 3'd4, trap_exp ? 32'd0 : 32'h8000_0000);
    rdy_cnt = 0;
    done_cnt = 0;
    bus.INSTR = {3'b111, 3'd7, 3'd7, 3'd0, 4'h0};
    bus.INSTR_VALID = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rdy_cnt += int'(bus.INSTR_READY);
      @(posedge CLK); #1;
      done_cnt += int'(bus.DONE);
    end
    bus.INSTR_VALID = 1'b0;
    check("stream_ready", rdy_cnt, 32'd3);
    check("stream_done", done_cnt, 32'd3);
    rd_chk("stream_r7", 3'd7, 32'd3);
    bus.INSTR = {3'b101, 3'd2, 3'd1, 3'd1, 4'h0};
    bus.INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.INSTR_VALID = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b0;
    #1;
    check("abort_alu_a", bus.ALU_A, 32'd0);
    check("abort_result", bus.RESULT, 32'd0);
    check("abort_of", {31'd0, bus.OF_STICKY}, 32'd0);
    check("abort_op", {29'd0, bus.ALU_OP}, 32'd0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      done_cnt += int'(bus.DONE);
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_ready", {31'd0, bus.INSTR_READY}, 32'd1);
    rd_chk("abort_r2", 3'd2, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
